// File: rtl/tl_error_slave.sv
// TileLink-UL/UH error slave: denies every A request with the matching D response and beat count.
// Define TL_ERROR_LOG_EN to build the fault log (error count and last faulting address).
module tl_error_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 14,
    parameter int SOURCE_W    = 5,
    parameter int SIZE_W      = 4,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [SIZE_W-1:0]   d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_corrupt,
    input  logic                err_clear,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   err_last_addr
);
    localparam int BYTES_LG = $clog2(DATA_W / 8);
    localparam int MAX_SIZE = (1 << SIZE_W) - 1;
    localparam int CNT_W    = (MAX_SIZE > BYTES_LG) ? (MAX_SIZE - BYTES_LG) : 1;
    localparam int PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QCNT_W   = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [2:0]          op;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
    } entry_t;

    // Index of the last beat: beats(size) - 1, where beats = max(1, 2^size / bytes-per-beat).
    function automatic logic [CNT_W-1:0] last_beat(input logic [SIZE_W-1:0] size);
        if (int'(size) <= BYTES_LG)
            return '0;
        return ~({CNT_W{1'b1}} << (int'(size) - BYTES_LG));
    endfunction

    function automatic logic [2:0] resp_op(input logic [2:0] op);
        logic [2:0] r;
        case (op)
            3'd0, 3'd1:       r = 3'd0;
            3'd2, 3'd3, 3'd4: r = 3'd1;
            3'd5:             r = 3'd2;
            default:          r = 3'd5;
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0]  a_cnt, d_cnt, d_last;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [QCNT_W-1:0] count;
    entry_t            mem [QUEUE_DEPTH];
    entry_t            head;
    logic              a_fire, push, d_fire, pop, head_data;

    assign a_ready   = (a_cnt != '0) || (count < QCNT_W'(QUEUE_DEPTH));
    assign a_fire    = a_valid && a_ready;
    assign push      = a_fire && (a_cnt == '0);
    assign head      = mem[rd_ptr];
    assign head_data = (head.op == 3'd1) || (head.op == 3'd5);
    assign d_last    = head_data ? last_beat(head.size) : '0;
    assign d_valid   = (count != '0);
    assign d_fire    = d_valid && d_ready;
    assign pop       = d_fire && (d_cnt == d_last);

    // Only the data-carrying A opcodes (0..3) span several beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            a_cnt <= '0;
        else if (a_fire && !a_opcode[2])
            a_cnt <= (a_cnt == last_beat(a_size)) ? '0 : a_cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            d_cnt <= '0;
        else if (d_fire)
            d_cnt <= pop ? '0 : d_cnt + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= '{op: resp_op(a_opcode), size: a_size, source: a_source};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + QCNT_W'(1);
                2'b01:   count <= count - QCNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset, so every D field is gated by d_valid.
    assign d_opcode  = d_valid ? head.op : '0;
    assign d_size    = d_valid ? head.size : '0;
    assign d_source  = d_valid ? head.source : '0;
    assign d_param   = '0;
    assign d_sink    = 1'b0;
    assign d_data    = '0;
    assign d_denied  = d_valid;
    assign d_corrupt = d_valid && head_data;

    logic unused_a;
    assign unused_a = ^{a_param, a_mask, a_corrupt};

`ifdef TL_ERROR_LOG_EN
    logic [15:0]       log_cnt;
    logic [ADDR_W-1:0] log_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            log_cnt  <= '0;
            log_addr <= '0;
        end else if (err_clear) begin
            log_cnt  <= push ? 16'd1 : 16'd0;
            log_addr <= push ? a_address : '0;
        end else if (push) begin
            if (log_cnt != 16'hFFFF)
                log_cnt <= log_cnt + 16'd1;
            log_addr <= a_address;
        end
    end

    assign err_count     = log_cnt;
    assign err_last_addr = log_addr;
`else
    logic unused_log;
    assign unused_log    = ^{err_clear, a_address};
    assign err_count     = '0;
    assign err_last_addr = '0;
`endif
endmodule

// File: doc/tl_error_slave.md
# tl_error_slave

Parametrised TileLink-UL/UH error slave with integrated request queue: it accepts any A-channel request and answers on D with a denied, and for data responses corrupt, response of the correct opcode and beat count. It sits behind the crossbar at unmapped address holes, in place of the fixed 32-bit, single-beat error device plus buffer pair. Width, queue depth and burst handling are generalised. It also carries an optional fault log that records the error count and the last faulting address.

## Interface
- DATA_W, 32, D/A data width in bits (power of 2, ≥8)
- ADDR_W, 14, address width
- SOURCE_W, 5, source ID width
- SIZE_W, 4, log2(bytes) size field width
- QUEUE_DEPTH, 2, pending-request FIFO entries (≥1)

- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- a_valid / a_ready  in / out  1 / 1  A handshake
- a_opcode, a_param  in  3, 3  A opcode, param (param ignored)
- a_size  in  SIZE_W  log2 bytes
- a_source  in  SOURCE_W  requester ID
- a_address  in  ADDR_W  request address
- a_mask  in  DATA_W/8  byte mask (ignored)
- a_corrupt  in  1  ignored
- d_valid / d_ready  out / in  1 / 1  D handshake
- d_opcode, d_param  out  3, 2  response opcode; param always 0
- d_size, d_source  out  SIZE_W, SOURCE_W  echoed from request
- d_sink  out  1  always 0
- d_denied  out  1  always 1 while d_valid
- d_data  out  DATA_W  always 0
- d_corrupt  out  1  1 on AccessAckData/GrantData beats, else 0
- err_clear  in  1  synchronous clear of the fault log
- err_count  out  16  saturating count of requests received
- err_last_addr  out  ADDR_W  address of the most recent request

## Operation
- beats(size) = max(1, 2^size / (DATA_W/8)).
- **A side**
  - A beat counter `a_cnt` tracks bursts on PutFull (0), PutPartial (1), ArithmeticData (2) and LogicalData (3), using beats(a_size).
  - Only the first beat of a request is enqueued: {opcode, size, source}.
  - Subsequent beats are accepted and discarded.
- **Opcode map:**
  - Put*/Put-burst → AccessAck (0), 1 beat.
  - Get (4), Arithmetic (2), Logical (3) → AccessAckData (1), beats(size).
  - Hint (5) → HintAck (2), 1 beat.
  - AcquireBlock/AcquirePerm (6/7) → GrantData (5), beats(size).
- **D side**
  - d_valid = FIFO non-empty.
  - D beat counter `d_cnt` advances on each d_valid&d_ready.
  - The head entry pops on the last beat's handshake, and `d_cnt` returns to 0.
  - All D fields stay stable while d_valid && !d_ready.
- **FIFO**
  - Circular, with wrap-around read and write pointers and a count register.
  - Push and pop in the same cycle leave the count unchanged.
- **Fault log**
  - On each first-beat A handshake: err_count += 1, saturating at 0xFFFF, and err_last_addr ← a_address.
  - err_clear zeroes both.
  - err_clear in the same cycle as a first-beat handshake gives err_count=1 and err_last_addr=a_address.

## Timing
- Reset values:
  - a_ready=1.
  - d_valid=0.
  - All d_* fields 0.
  - err_count=0, err_last_addr=0.
  - a_cnt=0, d_cnt=0, FIFO empty.
- Reset mid-burst discards all pending state. Beats that arrive after reset are treated as new first beats.
- a_ready = (a_cnt≠0) || (count < QUEUE_DEPTH). It is computed from registered state only; there is no same-cycle pop bypass.
- Latency: first beat accepted at cycle N → d_valid at N+1 at the earliest.
- With d_ready held at 1, an n-beat response occupies cycles N+1 … N+n. Back-to-back single-beat requests sustain one response per cycle when QUEUE_DEPTH ≥ 2.
- The A side is never blocked by D back-pressure except through a full FIFO.

## Configuration
- TL_ERROR_LOG_EN
  - Defined: the fault-log registers are built as described.
  - Undefined: err_count and err_last_addr are tied to 0, err_clear is ignored, and no log registers are instantiated.
  - Port list is identical in both builds.

## Test plan
- Get, size=2, source=7, address=0x1234 → one beat at N+1: opcode 1, size 2, source 7, denied 1, corrupt 1, data 0; err_count=1, err_last_addr=0x1234.
- PutFull, size=4 (4 beats at DATA_W=32) → a_ready high for all 4 beats; exactly one AccessAck, corrupt 0, denied 1.
- Get, size=5 with d_ready toggling 1/0 → 8 GrantData-free AccessAckData beats; fields stable on stalls; FIFO pops only on the 8th handshake.
- QUEUE_DEPTH=2, d_ready=0, three Gets offered → a_ready drops after 2 are accepted; raising d_ready drains them in order, then the third is accepted. This also exercises pointer wrap.
- AcquireBlock, size=3 at DATA_W=64 → 1 GrantData beat (opcode 5); Hint → HintAck (opcode 2), corrupt 0.
- err_clear pulsed in the same cycle as a Get to 0x0040, and a reset asserted mid-response → log reads 1/0x0040; after reset, d_valid=0 and err_count=0. With TL_ERROR_LOG_EN undefined, err_count stays 0 throughout.
